step_sequencer: RTL
===================

Name: step_sequencer

Overview:
Closed-loop motion controller for the signed 10-bit step counter. Accepts a target position through a valid/ready command interface and compares it with the counter's current count. Issues one-cycle step pulses with direction at a programmable rate until the count equals the target. Drives a rotating 4-phase one-hot coil pattern in lockstep with the counter and reports completion with a done pulse after a settle interval.

Parameters:
POS_WIDTH, 10, width of signed position/target (matches step counter count)
DIV_WIDTH, 16, width of step period divider
SETTLE_CYCLES, 4, idle cycles after motion ends before done

Ports:
clk  input  1  system clock, all logic on rising edge
reset_n  input  1  synchronous, active-low reset
cmd_valid  input  1  command offered
cmd_ready  output  1  controller can accept command (high only in IDLE)
cmd_target  input  POS_WIDTH  signed target position, sampled on accept
step_period  input  DIV_WIDTH  cycles between step pulses, sampled on accept; 0 treated as 1
position  input  POS_WIDTH  signed current count fed back from step counter
abort  input  1  stop motion immediately
step_enable  output  1  one-cycle step request to counter enable
step_up  output  1  direction to counter count_up; 1 = increment
coil  output  4  one-hot phase pattern
busy  output  1  high in MOVE and SETTLE
done  output  1  one-cycle pulse on return to IDLE after a command

Behaviour:
- One clock; reset is synchronous and active-low.
- Reset (reset_n=0 at an edge), from any state: state=IDLE, step_enable=0, step_up=0, coil=4'b0001, busy=0, done=0, divider=0, latched target/period=0. cmd_ready low while reset_n=0. Mid-move reset abandons the motion with no further pulses. Counter position is not touched; the counter has its own reset.
- States: IDLE, MOVE, SETTLE, DONE.
- IDLE:
  - cmd_ready=1 (combinational from state).
  - Accept on cmd_valid & cmd_ready: latch target and period (0 becomes 1), load divider with period-1.
  - Next state MOVE, or SETTLE if target==position at accept.
- MOVE:
  - Divider decrements each cycle.
  - When divider==0 and position!=target: next cycle step_enable=1 for exactly one cycle, step_up=(target>position, signed compare). Divider reloads period-1.
  - First pulse starts period cycles after the accepting edge; later pulses exactly period cycles apart.
  - period=1 gives one pulse per cycle. This is legal because the counter updates at the pulse's closing edge and position is current in the next cycle.
  - When position==target (no pulse in flight), go to SETTLE.
  - abort=1 goes to SETTLE; no pulse is issued in a cycle where abort was sampled high.
- Coil:
  - Updates on the same edge the counter updates (end of the step_enable cycle).
  - step_up=1: rotate left (0001→0010→0100→1000→0001).
  - step_up=0: rotate right.
  - Always exactly one bit set.
- SETTLE: wait SETTLE_CYCLES cycles, then DONE. abort is ignored here.
- DONE: done=1 for one cycle, then IDLE. The next command can be accepted in the cycle after done.
- cmd_valid outside IDLE is ignored; no queuing.
- Arithmetic: all compares are signed POS_WIDTH. Motion is always toward the target, so the counter never wraps at -512/511. A target of -512 from 511 requires 1023 pulses.
- busy=1 exactly in MOVE and SETTLE.

Decomposition:
- Package step_seq_pkg:
  - state enum (IDLE, MOVE, SETTLE, DONE)
  - COIL_RESET=4'b0001
  - default POS_WIDTH/DIV_WIDTH constants
- One sub-module, rate_divider: loadable down-counter with load, enable, and tick output (tick when count==0).

Test Plan:
- Reset with reset_n=0 for 2 cycles → coil=0001, step_enable=0, busy=0, done=0; cmd_ready=1 first cycle after release.
- position=0, target=+5, period=4 → exactly 5 step_enable pulses, step_up=1, 4 cycles apart, first 4 cycles after accept; coil ends 0010; done pulses 4+1 cycles after reaching 5.
- position=3, target=-2, period=1 → 5 consecutive pulses, step_up=0; coil 0001→1000→0100→0010→0001→1000; final position -2.
- target==position=7 → no pulses, busy for SETTLE_CYCLES, then one done pulse.
- Abort during move (target=+100, period=2, abort after third pulse) → no further pulses, position=3, done after settle; cmd_valid during busy not accepted.
- reset_n=0 mid-MOVE → pulses stop at that edge, state IDLE, coil=0001; step_period=0 behaves as 1; target=-512 from 511 → 1023 down pulses, no wrap.

Source files
------------

// File: rtl/step_seq_pkg.sv
// Shared types and constants for the step sequencer: FSM states, coil reset
// pattern, default widths and the coil rotation helper.
package step_seq_pkg;

  localparam int POS_WIDTH_DEF     = 10;
  localparam int DIV_WIDTH_DEF     = 16;
  localparam int SETTLE_CYCLES_DEF = 4;

  localparam logic [3:0] COIL_RESET = 4'b0001;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MOVE,
    ST_SETTLE,
    ST_DONE
  } state_e;

  // Left rotation follows increments, right rotation follows decrements.
  function automatic logic [3:0] coil_next(input logic [3:0] c, input logic up);
    return up ? {c[2:0], c[3]} : {c[0], c[3:1]};
  endfunction

endpackage

// File: rtl/step_sequencer_if.sv
// Command, feedback and drive signals of the step sequencer.
// master = controlling environment, slave = sequencer.
interface step_sequencer_if
  import step_seq_pkg::*;
#(
  parameter int POS_WIDTH = POS_WIDTH_DEF,
  parameter int DIV_WIDTH = DIV_WIDTH_DEF
);
  logic                        cmd_valid;
  logic                        cmd_ready;
  logic signed [POS_WIDTH-1:0] cmd_target;
  logic        [DIV_WIDTH-1:0] step_period;
  logic signed [POS_WIDTH-1:0] position;
  logic                        abort;
  logic                        step_enable;
  logic                        step_up;
  logic        [3:0]           coil;
  logic                        busy;
  logic                        done;

  modport master (
    output cmd_valid, cmd_target, step_period, position, abort,
    input  cmd_ready, step_enable, step_up, coil, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_target, step_period, position, abort,
    output cmd_ready, step_enable, step_up, coil, busy, done
  );
endinterface

// File: rtl/step_sequencer_rate_divider.sv
// Loadable down-counter pacing step pulses; tick is high while the count is zero.
// Load wins over enable; the count holds at zero until reloaded.
module rate_divider #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic             tick
);
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en && (count_q != '0)) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tick = (count_q == '0);

endmodule

// File: rtl/step_sequencer.sv
// Closed-loop step sequencer: drives step pulses toward a commanded target,
// rotates the coil pattern in lockstep, and pulses done after a settle interval.
module step_sequencer
  import step_seq_pkg::*;
#(
  parameter int POS_WIDTH     = POS_WIDTH_DEF,
  parameter int DIV_WIDTH     = DIV_WIDTH_DEF,
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
  input logic             clk,
  input logic             reset_n,
  step_sequencer_if.slave bus
);
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);

  state_e                      state_q, state_d;
  logic signed [POS_WIDTH-1:0] target_q, target_d;
  logic        [DIV_WIDTH-1:0] period_q, period_d;
  logic                        step_en_q, step_en_d;
  logic                        step_up_q, step_up_d;
  logic        [3:0]           coil_q, coil_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;
  logic        [SW-1:0]        settle_q, settle_d;

  logic                        div_load;
  logic        [DIV_WIDTH-1:0] div_val;
  logic                        div_tick;
  logic        [DIV_WIDTH-1:0] per_in;
  logic signed [POS_WIDTH-1:0] pos;
  logic signed [POS_WIDTH-1:0] pos_eff;

  assign per_in = (bus.step_period == '0) ? DIV_WIDTH'(1) : bus.step_period;
  assign pos    = bus.position;

  // A pulse in flight lands at the end of this cycle, so decide the next pulse
  // from the position the counter is about to hold; this allows back-to-back pulses.
  always_comb begin
    pos_eff = pos;
    if (step_en_q) begin
      pos_eff = step_up_q ? (pos + POS_WIDTH'(1)) : (pos - POS_WIDTH'(1));
    end
  end

  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    period_d  = period_q;
    step_en_d = 1'b0;
    step_up_d = step_up_q;
    coil_d    = coil_q;
    settle_d  = settle_q;
    div_load  = 1'b0;
    div_val   = period_q - DIV_WIDTH'(1);

    if (step_en_q) begin
      coil_d = coil_next(coil_q, step_up_q);
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid && bus.cmd_ready) begin
          target_d = bus.cmd_target;
          period_d = per_in;
          div_load = 1'b1;
          div_val  = per_in - DIV_WIDTH'(1);
          if (bus.cmd_target == pos) begin
            state_d  = ST_SETTLE;
            settle_d = SETTLE_LOAD;
          end else begin
            state_d = ST_MOVE;
          end
        end
      end
      ST_MOVE: begin
        if (bus.abort || (!step_en_q && (pos == target_q))) begin
          state_d  = ST_SETTLE;
          settle_d = SETTLE_LOAD;
        end else if (div_tick) begin
          div_load = 1'b1;
          if (pos_eff != target_q) begin
            step_en_d = 1'b1;
            step_up_d = (target_q > pos_eff);
          end
        end
      end
      ST_SETTLE: begin
        if (settle_q == '0) begin
          state_d = ST_DONE;
        end else begin
          settle_d = settle_q - SW'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d == ST_MOVE) || (state_d == ST_SETTLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      target_q  <= '0;
      period_q  <= '0;
      step_en_q <= 1'b0;
      step_up_q <= 1'b0;
      coil_q    <= COIL_RESET;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      settle_q  <= '0;
    end else begin
      state_q   <= state_d;
      target_q  <= target_d;
      period_q  <= period_d;
      step_en_q <= step_en_d;
      step_up_q <= step_up_d;
      coil_q    <= coil_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      settle_q  <= settle_d;
    end
  end

  rate_divider #(
    .WIDTH(DIV_WIDTH)
  ) u_rate_divider (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (div_load),
    .load_val (div_val),
    .en       (state_q == ST_MOVE),
    .tick     (div_tick)
  );

  assign bus.cmd_ready   = reset_n && (state_q == ST_IDLE);
  assign bus.step_enable = step_en_q;
  assign bus.step_up     = step_up_q;
  assign bus.coil        = coil_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;

endmodule
